// File: rtl/sr_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// sr_debounce_ctrl
//   Clocked front end for a set/reset latch stage. The raw S and R request
//   lines are asynchronous and may bounce. Each line goes through its own
//   synchronizer and debouncer. The debounced pair then drives a three-state
//   FSM, which produces a clean, registered Q/QB. The block also emits
//   one-cycle set/reset event pulses and an invalid flag.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles before a debounced value
//                     follows its synchronized input (>= 1)
//   SYNC_STAGES     : flip-flops per input synchronizer (>= 2)
//
// Ports
//   clk         in  : single clock, rising edge
//   rst         in  : asynchronous, active-high reset
//   S, R        in  : raw set / reset requests (asynchronous to clk)
//   Q           out : resolved latch state
//   QB          out : ~Q, except 0 while INVALID
//   set_pulse   out : one cycle on entry to SET
//   reset_pulse out : one cycle on entry to RESET from SET or INVALID
//   invalid     out : high while in INVALID
// -----------------------------------------------------------------------------
module sr_debounce_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic QB,
  output logic set_pulse,
  output logic reset_pulse,
  output logic invalid
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    RESET_ST   = 2'b00,
    SET_ST     = 2'b01,
    INVALID_ST = 2'b10
  } state_e;

  // Channel 0 carries S and channel 1 carries R throughout.
  logic [1:0]             raw_s;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [CW-1:0]          cnt_q  [2];
  logic [CW-1:0]          cnt_d  [2];
  logic [1:0]             db_q;
  logic [1:0]             db_d;
  logic                   s_db_s;
  logic                   r_db_s;

  state_e state_q, state_d;
  logic   q_q, qb_q, invalid_q, set_pulse_q, reset_pulse_q;

  assign raw_s  = {R, S};
  assign s_db_s = db_q[0];
  assign r_db_s = db_q[1];

  // Synchronizer shift and debounce counter next-state for both channels.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_s[i]};
      cnt_d[i]  = CNT_ZERO;
      db_d[i]   = db_q[i];
      if (sync_q[i][SYNC_STAGES-1] == db_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive disagreeing edge, so accept the new level.
        db_d[i]  = sync_q[i][SYNC_STAGES-1];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Synchronizer, counter and debounced-value registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {SYNC_STAGES{1'b0}};
        cnt_q[i]  <= CNT_ZERO;
      end
      db_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      db_q <= db_d;
    end
  end

  // Next-state resolution from the debounced pair only.
  always_comb begin
    state_d = state_q;
    case ({s_db_s, r_db_s})
      2'b10:   state_d = SET_ST;
      2'b01:   state_d = RESET_ST;
      2'b11:   state_d = INVALID_ST;
      2'b00: begin
        // Leaving INVALID on release is deterministic: always to RESET.
        if (state_q == INVALID_ST) begin
          state_d = RESET_ST;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State register plus outputs registered from the next state, so they change on the state edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_ST;
      q_q           <= 1'b0;
      qb_q          <= 1'b1;
      invalid_q     <= 1'b0;
      set_pulse_q   <= 1'b0;
      reset_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_q           <= (state_d == SET_ST);
      qb_q          <= (state_d == RESET_ST);
      invalid_q     <= (state_d == INVALID_ST);
      set_pulse_q   <= (state_d == SET_ST) && (state_q != SET_ST);
      reset_pulse_q <= (state_d == RESET_ST) && (state_q != RESET_ST);
    end
  end

  assign Q           = q_q;
  assign QB          = qb_q;
  assign invalid     = invalid_q;
  assign set_pulse   = set_pulse_q;
  assign reset_pulse = reset_pulse_q;

endmodule

// File: doc/sr_debounce_ctrl.md
# sr_debounce_ctrl

Clocked front end for the set/reset latch stage. Takes raw, possibly bouncing, asynchronous S and R request lines. It synchronizes and debounces each line, then resolves the pair through a small state machine into a clean registered Q/QB. It also emits one-cycle set/reset event pulses and an invalid-condition flag. Sits directly upstream of latch-consuming logic and replaces direct pushbutton-to-latch wiring.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must differ from its debounced value before the debounced value updates; legal range ≥1.
- SYNC_STAGES, 2: flip-flops per input synchronizer; legal range ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- S  in  1  raw set request, asynchronous to clk.
- R  in  1  raw reset request, asynchronous to clk.
- Q  out  1  resolved latch state.
- QB  out  1  complement output; equals ~Q except in INVALID, where it is 0.
- set_pulse  out  1  high for exactly one cycle on entry to SET.
- reset_pulse  out  1  high for exactly one cycle on entry to RESET from SET or INVALID.
- invalid  out  1  high while state is INVALID.

## Operation
- **Synchronizer:** SYNC_STAGES-deep flop chain per input, producing s_sync and r_sync.
- **Debounce:** one counter per input, width $clog2(DEBOUNCE_CYCLES+1), plus a debounced register (s_db, r_db).
  - Each edge where x_sync == x_db: cnt clears to 0.
  - Each edge where x_sync != x_db and cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - Each edge where x_sync != x_db and cnt == DEBOUNCE_CYCLES-1: x_db takes x_sync and cnt clears.
  - A synchronized pulse shorter than DEBOUNCE_CYCLES cycles never reaches x_db.
- **FSM states:** RESET_ST, SET_ST, INVALID_ST. The next state depends only on {s_db, r_db}:
  - 10: go to SET_ST.
  - 01: go to RESET_ST.
  - 11: go to INVALID_ST.
  - 00: hold in RESET_ST or SET_ST; INVALID_ST goes to RESET_ST (deterministic, no race).
- **Outputs decoded from the state register:**
  - RESET_ST: Q=0, QB=1.
  - SET_ST: Q=1, QB=0.
  - INVALID_ST: Q=0, QB=0, invalid=1.
- **Event pulses:** registered, asserted in the cycle after the transitioning edge.
  - set_pulse: any state other than SET_ST entering SET_ST.
  - reset_pulse: SET_ST or INVALID_ST entering RESET_ST.
  - Remaining in a state never pulses. set_pulse and reset_pulse are never high together.
- **Simultaneous debounce updates:** s_db and r_db may update on the same edge.
  - 00→11 goes straight to INVALID_ST.
  - 10→01 goes SET_ST→RESET_ST directly with reset_pulse.

## Timing
- **Reset values:** all sync flops, debounced registers and counters are 0; state is RESET_ST. Q=0, QB=1, set_pulse=0, reset_pulse=0, invalid=0.
- **rst behaviour:** takes effect immediately, without waiting for clk. It aborts any in-progress debounce; after release, a full DEBOUNCE_CYCLES run is required again.
- **Edge numbering:** an input change captured at edge 1 appears on x_sync after edge SYNC_STAGES. x_db updates at edge SYNC_STAGES+DEBOUNCE_CYCLES. The state register updates at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- **Latency:** defaults give 7 edges from the first sampling edge to the Q change. The pulse is high for the cycle following that edge.
- **Input stability:** inputs must hold for at least SYNC_STAGES+DEBOUNCE_CYCLES cycles to be guaranteed an effect.
- **Metastability:** only the first synchronizer stage may go metastable; no other logic samples S or R directly.

## Test plan
- **Reset:** assert rst mid-cycle with S=1, R=0 held → outputs go immediately (no clk edge) to Q=0, QB=1, invalid=0, set_pulse=0, reset_pulse=0. Release and hold S=R=0 for 20 cycles → no output change, no pulses.
- **Set latency (defaults):** S 0→1 before edge 1, R=0 → Q=1, QB=0 after edge 7 (not 6). set_pulse high for exactly the following cycle. Hold 20 cycles → no further pulse.
- **Glitch rejection:** S=1 for 3 cycles then 0 → Q stays 0, set_pulse never asserts. A 4-cycle S pulse → Q=1 with one set_pulse.
- **Invalid and recovery:** S=R=1 held 20 cycles → invalid=1, Q=0, QB=0. Then S=R=0 → state goes to RESET_ST, Q=0, QB=1, invalid=0, one reset_pulse.
- **Latch-style sequence:** apply {S,R} = 01, 11, 10, 00, 10, 00, 11, 10, each held 20 cycles. Per step, expect:
  - 01: Q/QB=0/1.
  - 11: 0/0 with invalid.
  - 10: 1/0 with set_pulse.
  - 00: 1/0.
  - 10: 1/0, no pulse.
  - 00: 1/0.
  - 11: 0/0 with invalid.
  - 10: 1/0 with set_pulse.
- **Reset mid-debounce:** S=1 applied; assert rst when the S counter reads 2, then release with S still 1 → counter restarts at 0. Q=1 only after a fresh 7-edge latency from the first post-reset edge.
